spi_slave_core: RTL and testbench



---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_slave_core.sv | 187 ++++++++++++++++++
 tb/tb_spi_slave_core.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI types: link state and clock mode
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - two-flop synchroniser plus history flop with edge pulses
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q, s2_q, hist_q;

    // Reset to the pin's idle level so leaving reset never fakes an edge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q   <= RST_VAL;
            s2_q   <= RST_VAL;
            hist_q <= RST_VAL;
        end else begin
            s1_q   <= d_i;
            s2_q   <= s1_q;
            hist_q <= s2_q;
        end
    end

    assign level_o = s2_q;
    assign rise_o  = s2_q & ~hist_q;
    assign fall_o  = ~s2_q & hist_q;

endmodule

// File: rtl/spi_slave_core.sv
// rtl/spi_slave_core.sv - oversampled SPI slave, any CPOL/CPHA, multi-word frames
module spi_slave_core
    import spi_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter bit               CPOL  = 1'b0,
    parameter bit               CPHA  = 1'b0,
    parameter logic [WIDTH-1:0] FILL  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sck,
    input  logic             ssel,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             frame_start,
    output logic             frame_end,
    output logic             tx_underrun
);

    localparam spi_mode_t MODE = '{cpol: CPOL, cpha: CPHA};
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic sck_lvl, sck_rise, sck_fall;
    logic ssel_lvl, ssel_rise, ssel_fall;
    logic mosi_s1_q, mosi_s2_q;
    logic unused_levels;

    spi_sync_edge #(.RST_VAL(MODE.cpol)) u_sck_sync (
        .clk_i(clk), .rst_i(rst), .d_i(sck),
        .level_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_ssel_sync (
        .clk_i(clk), .rst_i(rst), .d_i(ssel),
        .level_o(ssel_lvl), .rise_o(ssel_rise), .fall_o(ssel_fall)
    );

    assign unused_levels = sck_lvl ^ ssel_lvl;

    always_ff @(posedge clk) begin
        if (rst) begin
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
        end else begin
            mosi_s1_q <= mosi;
            mosi_s2_q <= mosi_s1_q;
        end
    end

    logic lead_ev, trail_ev, sample_ev, shift_ev;
    assign lead_ev   = MODE.cpol ? sck_fall : sck_rise;
    assign trail_ev  = MODE.cpol ? sck_rise : sck_fall;
    assign sample_ev = MODE.cpha ? trail_ev : lead_ev;
    assign shift_ev  = MODE.cpha ? lead_ev : trail_ev;

    spi_state_e       state_q, state_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d;
    logic [WIDTH-2:0] rx_shift_q, rx_shift_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             rx_valid_q, rx_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             frame_end_q, frame_end_d;
    logic             tx_underrun_q, tx_underrun_d;
    logic             load;
    logic [WIDTH-1:0] rx_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            bitcnt_q      <= '0;
            rx_shift_q    <= '0;
            rx_data_q     <= '0;
            tx_shift_q    <= '0;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            rx_valid_q    <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            tx_underrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bitcnt_q      <= bitcnt_d;
            rx_shift_q    <= rx_shift_d;
            rx_data_q     <= rx_data_d;
            tx_shift_q    <= tx_shift_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            rx_valid_q    <= rx_valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            tx_underrun_q <= tx_underrun_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bitcnt_d      = bitcnt_q;
        rx_shift_d    = rx_shift_q;
        rx_data_d     = rx_data_q;
        tx_shift_d    = tx_shift_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        rx_valid_d    = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        tx_underrun_d = 1'b0;
        load          = 1'b0;
        rx_word       = {rx_shift_q, mosi_s2_q};

        case (state_q)
            IDLE: begin
                if (ssel_fall) begin
                    state_d       = ACTIVE;
                    frame_start_d = 1'b1;
                    bitcnt_d      = '0;
                    load          = ~MODE.cpha;
                end
            end
            ACTIVE: begin
                if (sample_ev) begin
                    rx_shift_d = rx_word[WIDTH-2:0];
                    if (bitcnt_q == LAST) begin
                        rx_data_d  = rx_word;
                        rx_valid_d = 1'b1;
                        bitcnt_d   = '0;
                        load       = ~MODE.cpha;
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
                if (shift_ev) begin
                    if (MODE.cpha && bitcnt_q == '0) begin
                        load = 1'b1;
                    end else begin
                        tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
                    end
                end
                // A final sample landing with deselect still delivers its word
                if (ssel_rise) begin
                    state_d     = IDLE;
                    frame_end_d = 1'b1;
                    bitcnt_d    = '0;
                    tx_shift_d  = '0;
                    load        = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            if (hold_full_q) begin
                tx_shift_d  = hold_q;
                hold_full_d = 1'b0;
            end else begin
                tx_shift_d    = FILL;
                tx_underrun_d = 1'b1;
            end
        end

        // Gated on the old hold_full, so a same-cycle load never sees this word
        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    assign miso        = (state_q == ACTIVE) & tx_shift_q[WIDTH-1];
    assign miso_oe     = (state_q == ACTIVE);
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_ready    = ~hold_full_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// tb/tb_spi_slave_core.sv - scoreboard bench over five slave variants sharing one SPI bus
module tb_spi_slave_core;

    localparam int N = 5;
    localparam int H = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sck = 1'b0;
    logic ssel_raw = 1'b1;
    logic mosi = 1'b0;
    int   sel_idx = 0;

    always #5 clk = ~clk;

    logic [15:0] tx_data_a [N];
    logic        tx_valid_a [N];
    logic [15:0] rx_data_a [N];
    logic        rx_valid_a [N];
    logic        tx_ready_a [N];
    logic        miso_a [N];
    logic        miso_oe_a [N];
    logic        fs_a [N];
    logic        fe_a [N];
    logic        ur_a [N];

    // Instances 0..3: WIDTH 8, SPI modes 0..3. Instance 4: WIDTH 16, mode 3.
    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int W = (g == 4) ? 16 : 8;
        localparam bit POL = (g == 4) || (g >= 2);
        localparam bit PHA = (g == 4) || (g % 2 == 1);
        localparam logic [15:0] FILL_K = (g == 4) ? 16'hF00D : 16'h00E7;
        logic [W-1:0] rxd;
        logic         ss;
        assign ss = ssel_raw | (sel_idx != g);
        spi_slave_core #(.WIDTH(W), .CPOL(POL), .CPHA(PHA), .FILL(W'(FILL_K))) dut (
            .clk(clk), .rst(rst), .sck(sck), .ssel(ss), .mosi(mosi),
            .miso(miso_a[g]), .miso_oe(miso_oe_a[g]),
            .rx_data(rxd), .rx_valid(rx_valid_a[g]),
            .tx_data(tx_data_a[g][W-1:0]), .tx_valid(tx_valid_a[g]), .tx_ready(tx_ready_a[g]),
            .frame_start(fs_a[g]), .frame_end(fe_a[g]), .tx_underrun(ur_a[g])
        );
        assign rx_data_a[g] = 16'(rxd);
    end

    typedef struct {
        int          idx;
        logic [15:0] data;
    } rx_exp_t;

    rx_exp_t exp_q[$];
    rx_exp_t e;
    int n_cmp = 0;
    int n_bad = 0;
    int fs_cnt [N];
    int fe_cnt [N];
    int ur_cnt [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic bit pol_of(input int k);
        return (k == 4) || (k >= 2);
    endfunction

    function automatic bit pha_of(input int k);
        return (k == 4) || (k % 2 == 1);
    endfunction

    initial begin
        foreach (fs_cnt[k]) begin
            fs_cnt[k] = 0;
            fe_cnt[k] = 0;
            ur_cnt[k] = 0;
        end
    end

    // Monitor: pops the scoreboard on every rx_valid pulse, tallies frame events
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (fs_a[k]) fs_cnt[k]++;
            if (fe_a[k]) fe_cnt[k]++;
            if (ur_a[k]) ur_cnt[k]++;
            if (rx_valid_a[k]) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rx_unexpected: inst %0d got %h expected no word", k, rx_data_a[k]);
                end else begin
                    e = exp_q.pop_front();
                    chk("rx_inst", k, e.idx);
                    chk("rx_data", {16'h0, rx_data_a[k]}, {16'h0, e.data});
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic offer(input int k, input logic [15:0] d);
        int t;
        t = 0;
        while (!tx_ready_a[k] && t < 200) begin
            tick(1);
            t++;
        end
        if (!tx_ready_a[k]) begin
            chk("tx_ready_timeout", {31'h0, tx_ready_a[k]}, 32'h1);
        end else begin
            tx_data_a[k]  = d;
            tx_valid_a[k] = 1'b1;
            tick(1);
            tx_valid_a[k] = 1'b0;
        end
    endtask

    task automatic open_frame(input int k);
        sel_idx = k;
        sck = pol_of(k);
        tick(4);
        ssel_raw = 1'b0;
        tick(H);
    endtask

    task automatic close_frame();
        tick(H);
        ssel_raw = 1'b1;
        tick(2 * H);
    endtask

    task automatic bits(input int k, input logic [15:0] dout, input int nb, input int w,
                        output logic [15:0] din);
        logic pol, pha, b;
        pol = pol_of(k);
        pha = pha_of(k);
        din = '0;
        for (int i = 0; i < nb; i++) begin
            b = dout[w-1-i];
            if (!pha) begin
                mosi = b;
                tick(H);
                sck = ~pol;
                din = {din[14:0], miso_a[k]};
                tick(H);
                sck = pol;
            end else begin
                sck = ~pol;
                mosi = b;
                tick(H);
                sck = pol;
                din = {din[14:0], miso_a[k]};
                tick(H);
            end
        end
    endtask

    task automatic xfer(input int k, input int w, input logic [15:0] dout,
                        input logic [15:0] miso_exp, input string name);
        logic [15:0] din;
        rx_exp_t x;
        x.idx  = k;
        x.data = dout;
        exp_q.push_back(x);
        bits(k, dout, w, w, din);
        chk(name, {16'h0, din}, {16'h0, miso_exp});
    endtask

    task automatic chk_reset(input int k);
        chk("rst_miso",        {31'h0, miso_a[k]},     32'h0);
        chk("rst_miso_oe",     {31'h0, miso_oe_a[k]},  32'h0);
        chk("rst_rx_data",     {16'h0, rx_data_a[k]},  32'h0);
        chk("rst_rx_valid",    {31'h0, rx_valid_a[k]}, 32'h0);
        chk("rst_tx_ready",    {31'h0, tx_ready_a[k]}, 32'h1);
        chk("rst_frame_start", {31'h0, fs_a[k]},       32'h0);
        chk("rst_frame_end",   {31'h0, fe_a[k]},       32'h0);
        chk("rst_tx_underrun", {31'h0, ur_a[k]},       32'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int fs0, fe0, ur0;
        logic [15:0] din;
        logic [15:0] rx_prev;
        foreach (tx_valid_a[k]) begin
            tx_valid_a[k] = 1'b0;
            tx_data_a[k]  = '0;
        end
        rst = 1'b1;
        tick(3);
        chk_reset(0);
        chk_reset(4);
        rst = 1'b0;
        tick(4);

        // Mode 0, single word
        fs0 = fs_cnt[0];
        fe0 = fe_cnt[0];
        offer(0, 16'h003C);
        chk("tx_ready_after_hs", {31'h0, tx_ready_a[0]}, 32'h0);
        open_frame(0);
        chk("miso_oe_active", {31'h0, miso_oe_a[0]}, 32'h1);
        chk("tx_ready_after_load", {31'h0, tx_ready_a[0]}, 32'h1);
        xfer(0, 8, 16'h00A5, 16'h003C, "m0_miso");
        close_frame();
        chk("m0_frame_start_cnt", fs_cnt[0] - fs0, 1);
        chk("m0_frame_end_cnt", fe_cnt[0] - fe0, 1);

        // Mode 1, three words back-to-back, only two offered
        ur0 = ur_cnt[1];
        offer(1, 16'h0010);
        open_frame(1);
        fork
            offer(1, 16'h0020);
        join_none
        xfer(1, 8, 16'h0001, 16'h0010, "b2b_miso0");
        xfer(1, 8, 16'h0002, 16'h0020, "b2b_miso1");
        xfer(1, 8, 16'h0003, 16'h00E7, "b2b_miso2");
        close_frame();
        chk("b2b_underrun_cnt", ur_cnt[1] - ur0, 1);

        // Modes 1, 2, 3 at WIDTH 8
        for (int k = 1; k <= 3; k++) begin
            offer(k, 16'h005A);
            open_frame(k);
            xfer(k, 8, 16'h00C3, 16'h005A, "mode_miso");
            close_frame();
        end

        // WIDTH 16, mode 3: second word proves the counter wrapped at 15
        offer(4, 16'h1234);
        open_frame(4);
        xfer(4, 16, 16'hBEEF, 16'h1234, "w16_miso0");
        xfer(4, 16, 16'h0F0F, 16'hF00D, "w16_miso1");
        close_frame();

        // Mid-word deselect after 5 bits, then a clean frame
        fe0 = fe_cnt[0];
        rx_prev = rx_data_a[0];
        open_frame(0);
        bits(0, 16'h00FF, 5, 8, din);
        chk("partial_miso", {16'h0, din}, 32'h1C);
        close_frame();
        chk("partial_frame_end", fe_cnt[0] - fe0, 1);
        chk("partial_rx_kept", {16'h0, rx_data_a[0]}, {16'h0, rx_prev});
        offer(0, 16'h0081);
        open_frame(0);
        xfer(0, 8, 16'h0077, 16'h0081, "after_partial_miso");
        close_frame();

        // Reset after 3 bits with hold full, then a clean frame
        open_frame(0);
        offer(0, 16'h0099);
        bits(0, 16'h00AA, 3, 8, din);
        rst = 1'b1;
        tick(1);
        chk_reset(0);
        rst = 1'b0;
        ssel_raw = 1'b1;
        sck = pol_of(0);
        tick(2 * H);
        offer(0, 16'h00D2);
        open_frame(0);
        xfer(0, 8, 16'h005E, 16'h00D2, "after_rst_miso");
        close_frame();

        tick(20);
        chk("rx_pending", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
